// File: rtl/mul5_pkg.sv
// Shared definitions for the 5-bit multiplier datapath: product width, MAC FSM states
// and the overflow-free accumulator width helper.
package mul5_pkg;

    localparam int unsigned MUL5_OP_W    = 5;
    localparam int unsigned MUL5_PROD_W  = 2 * MUL5_OP_W;
    localparam int unsigned MUL5_N_TERMS = 4;

    // Smallest accumulator width that can never overflow for n_terms products of prod_w bits
    function automatic int unsigned mul5_acc_w(input int unsigned prod_w, input int unsigned n_terms);
        return prod_w + $clog2(n_terms);
    endfunction

    localparam int unsigned MUL5_ACC_W = mul5_acc_w(MUL5_PROD_W, MUL5_N_TERMS);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } mul5_state_e;

endpackage

// File: rtl/mul5_prod_accum.sv
// MAC tail: sums N_TERMS products into one result over valid/ready handshakes.
// Optional saturation on overflow is enabled by defining MUL5_ACC_SAT_EN.
module mul5_prod_accum
    import mul5_pkg::*;
#(
    parameter int unsigned PROD_W  = MUL5_PROD_W,
    parameter int unsigned N_TERMS = MUL5_N_TERMS,
    parameter int unsigned ACC_W   = MUL5_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf
);

    localparam int unsigned SUM_W = ACC_W + 1;
    localparam int unsigned CNT_W = $clog2(N_TERMS);

    mul5_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic               out_ovf_q, out_ovf_d;

    logic [SUM_W-1:0]   sum_c;
    logic [ACC_W-1:0]   next_acc_c;
    logic               grp_ovf_c;
    logic               last_beat_c;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_ACC;
            cnt_q     <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            out_sum_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            out_sum_q <= out_sum_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    // Next-state, counter and accumulator datapath
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        out_sum_d   = out_sum_q;
        out_ovf_d   = out_ovf_q;

        sum_c       = SUM_W'(acc_q) + SUM_W'(in_prod);
        grp_ovf_c   = ovf_q | sum_c[ACC_W];
        last_beat_c = (cnt_q == CNT_W'(N_TERMS - 1));
`ifdef MUL5_ACC_SAT_EN
        // Once clamped, any further add re-overflows, so the value stays pinned at max
        next_acc_c  = sum_c[ACC_W] ? {ACC_W{1'b1}} : sum_c[ACC_W-1:0];
`else
        next_acc_c  = sum_c[ACC_W-1:0];
`endif

        case (state_q)
            ST_ACC: begin
                if (in_valid) begin
                    if (last_beat_c) begin
                        out_sum_d = next_acc_c;
`ifdef MUL5_ACC_SAT_EN
                        out_ovf_d = grp_ovf_c;
`else
                        out_ovf_d = 1'b0;
`endif
                        acc_d     = '0;
                        ovf_d     = 1'b0;
                        cnt_d     = '0;
                        state_d   = ST_OUT;
                    end else begin
                        acc_d     = next_acc_c;
                        ovf_d     = grp_ovf_c;
                        cnt_d     = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // Handshake decode from state
    always_comb begin
        in_ready  = (state_q == ST_ACC);
        out_valid = (state_q == ST_OUT);
    end

    assign out_sum = out_sum_q;
    assign out_ovf = out_ovf_q;

endmodule

// File: tb/tb_mul5_prod_accum.sv
// Scoreboard bench for mul5_prod_accum: directed product groups, expected results queued at issue
// and popped by an independent output monitor. Honours MUL5_ACC_SAT_EN for overflow expectations.
module tb_mul5_prod_accum;

    localparam int unsigned PROD_W  = 10;
    localparam int unsigned N_TERMS = 4;
    localparam int unsigned ACC_W   = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic             ovf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    mul5_prod_accum #(
        .PROD_W (PROD_W),
        .N_TERMS(N_TERMS),
        .ACC_W  (ACC_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_prod  (in_prod),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int sum, input logic ovf);
        exp_t e;
        e.sum = ACC_W'(sum);
        e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    // Drives one beat from posedge+1 and returns at posedge+1 after it transfers
    task automatic send_beat(input int v);
        int waited = 0;
        in_valid = 1'b1;
        in_prod  = PROD_W'(v);
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: in_ready stayed 0 for value %0d", v);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic gap(input int junk);
        in_valid = 1'b0;
        in_prod  = PROD_W'(junk);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: compares every completed output handshake against the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got sum=%0d ovf=%0d expected none", out_sum, out_ovf);
            end else begin
                e = exp_q.pop_front();
                chk("result_sum", int'(out_sum), int'(e.sum));
                chk("result_ovf", int'(out_ovf), int'(e.ovf));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b1;

        // Reset held two cycles, then released
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sum",   int'(out_sum),   0);
        chk("rst_out_ovf",   int'(out_ovf),   0);
        chk("rst_in_ready",  int'(in_ready),  1);
        @(posedge clk);
        #1;

        // Back-to-back group with consumer always ready
        push_exp(156, 1'b0);
        send_beat(15);
        send_beat(63);
        send_beat(15);
        send_beat(63);
        @(negedge clk);
        chk("latency_out_valid", int'(out_valid), 1);
        chk("latency_in_ready",  int'(in_ready),  0);
        @(negedge clk);
        chk("rearm_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Same group stalled by consumer; next group's first beat waits upstream
        out_ready = 1'b0;
        push_exp(156, 1'b0);
        send_beat(15);
        send_beat(63);
        send_beat(15);
        send_beat(63);
        in_valid = 1'b1;
        in_prod  = PROD_W'(7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_in_ready",  int'(in_ready),  0);
            chk("stall_out_sum",   int'(out_sum),   156);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push_exp(28, 1'b0);
        send_beat(7);
        send_beat(7);
        send_beat(7);
        send_beat(7);

        // Gapped valid: idle cycles must not advance the count or add data
        push_exp(100, 1'b0);
        send_beat(10);
        gap(99);
        send_beat(20);
        gap(99);
        send_beat(30);
        send_beat(40);

        // Overflow at ACC_W=10
`ifdef MUL5_ACC_SAT_EN
        push_exp(1023, 1'b1);
`else
        push_exp(978, 1'b0);
`endif
        send_beat(1000);
        send_beat(1000);
        send_beat(1);
        send_beat(1);

        // Sticky overflow must clear for the following group
        push_exp(4, 1'b0);
        send_beat(1);
        send_beat(1);
        send_beat(1);
        send_beat(1);

        // Reset mid-group discards the partial sum
        send_beat(5);
        send_beat(6);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready",  int'(in_ready),  1);
        @(posedge clk);
        #1;
        push_exp(10, 1'b0);
        send_beat(1);
        send_beat(2);
        send_beat(3);
        send_beat(4);

        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_pending", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        chk("idle_out_valid", int'(out_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
